// File: rtl/mod31_residue_check.sv
// rtl/mod31_residue_check.sv - three-stage mod-31 residue checker for ADD/SUB/MUL results
module mod31_residue_check #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [63:0]      in_res,
  input  logic             in_cout,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;

  // End-around-carry fold; three passes bring any 10-bit sum into 0..31.
  function automatic logic [4:0] fold31(input logic [9:0] s);
    logic [9:0] t;
    t = s;
    for (int i = 0; i < 3; i++) t = {5'd0, t[9:5]} + {5'd0, t[4:0]};
    return t[4:0];
  endfunction

  // Every 5-bit chunk weighs 1 mod 31, so 32-bit values reuse this zero-extended.
  function automatic logic [4:0] res31(input logic [63:0] x);
    logic [64:0] xp;
    logic [9:0]  s;
    xp = {1'b0, x};
    s  = '0;
    for (int i = 0; i < 13; i++) s = s + {5'd0, xp[5*i +: 5]};
    return fold31(s);
  endfunction

  function automatic logic [4:0] mul31(input logic [4:0] a, input logic [4:0] b);
    logic [9:0] aa;
    logic [9:0] s;
    aa = {a, a};
    s  = '0;
    for (int i = 0; i < 5; i++) if (b[i]) s = s + {5'd0, aa[(5-i) +: 5]};
    return fold31(s);
  endfunction

  function automatic logic is_zero(input logic [4:0] x);
    return (x == 5'd0) || (x == 5'd31);
  endfunction

  logic             v1, v2;
  logic             ready1, ready2, ready3;
  logic [4:0]       ra1, rb1, rr1;
  logic             cin1, cout1;
  logic [1:0]       op1, op2;
  logic [TAG_W-1:0] tag1, tag2;
  logic [4:0]       pred2, act2;
  logic [31:0]      b_sel;
  logic [4:0]       ra_d, rb_d, rr_d, pred_d, act_d;
  logic             err_d, fire;

  assign ready3   = !out_valid || out_ready;
  assign ready2   = !v2 || ready3;
  assign ready1   = !v1 || ready2;
  assign in_ready = ready1;

  always_comb begin
    b_sel = (in_op == OP_SUB) ? ~in_b : in_b;
    ra_d  = res31({32'd0, in_a});
    rb_d  = res31({32'd0, b_sel});
    rr_d  = (in_op == OP_MUL) ? res31(in_res) : res31({32'd0, in_res[31:0]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      ra1   <= '0;
      rb1   <= '0;
      rr1   <= '0;
      cin1  <= 1'b0;
      cout1 <= 1'b0;
      op1   <= '0;
      tag1  <= '0;
    end else if (ready1) begin
      v1 <= in_valid;
      if (in_valid) begin
        ra1   <= ra_d;
        rb1   <= rb_d;
        rr1   <= rr_d;
        cin1  <= (in_op == OP_SUB);
        cout1 <= in_cout;
        op1   <= in_op;
        tag1  <= in_tag;
      end
    end
  end

  // 2^32 = 4 mod 31, so the carry-out adds 4 to the low-word residue.
  always_comb begin
    pred_d = (op1 == OP_MUL) ? mul31(ra1, rb1)
                             : fold31({5'd0, ra1} + {5'd0, rb1} + {9'd0, cin1});
    act_d  = (op1 == OP_MUL) ? rr1 : fold31({5'd0, rr1} + (cout1 ? 10'd4 : 10'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      pred2 <= '0;
      act2  <= '0;
      op2   <= '0;
      tag2  <= '0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        pred2 <= pred_d;
        act2  <= act_d;
        op2   <= op1;
        tag2  <= tag1;
      end
    end
  end

  always_comb begin
    err_d = (op2 != OP_NOP) &&
            !((pred2 == act2) || (is_zero(pred2) && is_zero(act2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (ready3) begin
      out_valid <= v2;
      if (v2) begin
        out_err <= err_d;
        out_tag <= tag2;
      end
    end
  end

  assign fire = out_valid && out_ready && out_err;

  // A clear that coincides with a delivered error keeps that error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clr) begin
      err_sticky <= fire;
      err_count  <= fire ? CNT_W'(1) : '0;
    end else if (fire) begin
      err_sticky <= 1'b1;
      if (err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
